// File: rtl/rtype_seq_pkg.sv
// Shared state codes, ALU op codes, funct codes and instruction field positions
// for the R-type execution sequencer.
package rtype_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_FETCH     = 3'd1;
  localparam state_t S_DECODE    = 3'd2;
  localparam state_t S_EXECUTE   = 3'd3;
  localparam state_t S_WRITEBACK = 3'd4;
  localparam state_t S_HALTED    = 3'd5;
  localparam state_t S_TRAP      = 3'd6;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [2:0] alu_op;
    logic       shift_sel;
    logic       sltu_sel;
  } ctrl_t;

endpackage

// File: rtl/rtype_exec_sequencer_decoder.sv
// Combinational decode of an instruction word into register fields, ALU
// controls, a legality flag and a HALT detect.
module rtype_decoder
  import rtype_seq_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        legal,
  output logic        halt
);

  always_comb begin
    ctrl.rs        = ir[RS_HI:RS_LO];
    ctrl.rt        = ir[RT_HI:RT_LO];
    ctrl.rd        = ir[RD_HI:RD_LO];
    ctrl.alu_op    = ALU_AND;
    ctrl.shift_sel = 1'b0;
    ctrl.sltu_sel  = 1'b0;
    legal          = (ir[OPCODE_HI:OPCODE_LO] == 6'd0);
    case (ir[FUNCT_HI:FUNCT_LO])
      F_ADD:  ctrl.alu_op = ALU_ADD;
      F_SUB:  ctrl.alu_op = ALU_SUB;
      F_AND:  ctrl.alu_op = ALU_AND;
      F_OR:   ctrl.alu_op = ALU_OR;
      F_SLT:  begin ctrl.alu_op = ALU_SLT;  ctrl.sltu_sel = 1'b1; end
      F_SLTU: begin ctrl.alu_op = ALU_SLTU; ctrl.sltu_sel = 1'b1; end
      F_SLL:  begin ctrl.alu_op = ALU_SLL;  ctrl.shift_sel = 1'b1; end
      F_SRL:  begin ctrl.alu_op = ALU_SRL;  ctrl.shift_sel = 1'b1; end
      default: legal = 1'b0;
    endcase
    // Whole-word compare, so the shamt bits take part in HALT detection too
    halt = (ir == HALT_WORD);
  end

endmodule

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back controller for the R-type datapath.
// Define RTYPE_ILLEGAL_TRAP_EN to trap on unsupported words instead of skipping them.
module rtype_exec_sequencer
  import rtype_seq_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter logic [31:0]     HALT_WORD = 32'hFC00_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rf_rs,
  output logic [4:0]      rf_rt,
  output logic [4:0]      rf_rd,
  output logic            rf_rd_en,
  output logic            rf_wr_en,
  output logic [2:0]      alu_op,
  output logic            shift_sel,
  output logic            sltu_sel,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
`ifdef RTYPE_ILLEGAL_TRAP_EN
  ,
  output logic            trap,
  output logic [PC_W-1:0] trap_pc
`endif
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  ctrl_t           ctrl_q;
  ctrl_t           dec_ctrl;
  logic            dec_legal;
  logic            dec_halt;
  logic            restart;
`ifdef RTYPE_ILLEGAL_TRAP_EN
  logic [PC_W-1:0] trap_pc_q;
`endif

  rtype_decoder #(.HALT_WORD(HALT_WORD)) u_decoder (
    .ir    (ir),
    .ctrl  (dec_ctrl),
    .legal (dec_legal),
    .halt  (dec_halt)
  );

  // start is only honoured from a resting state; mid-run pulses are dropped
  always_comb begin
    restart = start && ((state == S_IDLE) || (state == S_HALTED));
`ifdef RTYPE_ILLEGAL_TRAP_EN
    if (start && (state == S_TRAP)) restart = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= START_PC;
      ir      <= '0;
      ctrl_q  <= '0;
      retired <= '0;
    end else if (restart) begin
      state   <= S_FETCH;
      pc      <= START_PC;
      retired <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_halt) begin
            state <= S_HALTED;
          end else if (!dec_legal) begin
`ifdef RTYPE_ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            pc    <= pc + PC_W'(1);
            state <= S_FETCH;
`endif
          end else begin
            ctrl_q <= dec_ctrl;
            state  <= S_EXECUTE;
          end
        end
        S_EXECUTE:   state <= S_WRITEBACK;
        S_WRITEBACK: begin
          if (retired != 16'hFFFF) retired <= retired + 16'd1;
          pc    <= pc + PC_W'(1);
          state <= S_FETCH;
        end
        S_IDLE, S_HALTED: state <= state;
`ifdef RTYPE_ILLEGAL_TRAP_EN
        S_TRAP: state <= state;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RTYPE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_pc_q <= '0;
    end else if ((state == S_DECODE) && !dec_halt && !dec_legal) begin
      trap_pc_q <= pc;
    end
  end

  assign trap    = (state == S_TRAP);
  assign trap_pc = trap_pc_q;
`endif

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign rf_rs     = ctrl_q.rs;
  assign rf_rt     = ctrl_q.rt;
  assign rf_rd     = ctrl_q.rd;
  assign alu_op    = ctrl_q.alu_op;
  assign shift_sel = ctrl_q.shift_sel;
  assign sltu_sel  = ctrl_q.sltu_sel;
  assign rf_rd_en  = (state == S_EXECUTE);
  assign rf_wr_en  = (state == S_WRITEBACK) && (ctrl_q.rd != 5'd0);
  assign busy      = (state != S_IDLE) && (state != S_HALTED);
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Self-checking bench for rtype_exec_sequencer: directed scenarios plus random
// programs checked against a behavioural instruction-level model.
module tb_rtype_exec_sequencer;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [2:0] op;
    logic       sh;
    logic       sl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  logic        start_a = 1'b0, req_a, valid_a, rd_en_a, wr_en_a, sh_a, sl_a, busy_a, halted_a;
  logic [7:0]  addr_a;
  logic [31:0] rdata_a;
  logic [4:0]  rs_a, rt_a, rd_a;
  logic [2:0]  op_a;
  logic [15:0] ret_a;
  logic        start_b = 1'b0, req_b, valid_b, rd_en_b, wr_en_b, sh_b, sl_b, busy_b, halted_b;
  logic [1:0]  addr_b;
  logic [31:0] rdata_b;
  logic [4:0]  rs_b, rt_b, rd_b;
  logic [2:0]  op_b;
  logic [15:0] ret_b;
`ifdef RTYPE_ILLEGAL_TRAP_EN
  logic       trap_a, trap_b;
  logic [7:0] trap_pc_a;
  logic [1:0] trap_pc_b;
`endif

  rtype_exec_sequencer #(.PC_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start_a),
    .imem_req(req_a), .imem_addr(addr_a), .imem_valid(valid_a), .imem_rdata(rdata_a),
    .rf_rs(rs_a), .rf_rt(rt_a), .rf_rd(rd_a), .rf_rd_en(rd_en_a), .rf_wr_en(wr_en_a),
    .alu_op(op_a), .shift_sel(sh_a), .sltu_sel(sl_a), .busy(busy_a), .halted(halted_a),
    .retired(ret_a)
`ifdef RTYPE_ILLEGAL_TRAP_EN
    , .trap(trap_a), .trap_pc(trap_pc_a)
`endif
  );

  rtype_exec_sequencer #(.PC_W(2)) u_small (
    .clk(clk), .reset(reset), .start(start_b),
    .imem_req(req_b), .imem_addr(addr_b), .imem_valid(valid_b), .imem_rdata(rdata_b),
    .rf_rs(rs_b), .rf_rt(rt_b), .rf_rd(rd_b), .rf_rd_en(rd_en_b), .rf_wr_en(wr_en_b),
    .alu_op(op_b), .shift_sel(sh_b), .sltu_sel(sl_b), .busy(busy_b), .halted(halted_b),
    .retired(ret_b)
`ifdef RTYPE_ILLEGAL_TRAP_EN
    , .trap(trap_b), .trap_pc(trap_pc_b)
`endif
  );

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];
  int fixed_wait_a = 0;
  bit rand_wait_a = 1'b0;

  // Instruction memory for the wide instance: a fresh wait count per fetch
  initial begin : resp_a
    int left;
    left = 0; valid_a = 1'b0; rdata_a = '0;
    forever begin
      @(negedge clk);
      if (req_a) begin
        if (left > 0) begin left--; valid_a = 1'b0; end
        else begin valid_a = 1'b1; rdata_a = mem_a[addr_a]; end
      end else begin
        valid_a = 1'b0;
        left = rand_wait_a ? int'($urandom_range(0, 3)) : fixed_wait_a;
      end
    end
  end

  initial begin : resp_b
    valid_b = 1'b0; rdata_b = '0;
    forever begin
      @(negedge clk);
      valid_b = req_b;
      rdata_b = mem_b[addr_b];
    end
  end

  // Reference decode straight from the instruction-set table
  function automatic bit model_decode(input logic [31:0] w, output exp_t e);
    e = '0;
    e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11];
    if (w[31:26] != 6'd0) return 1'b0;
    case (w[5:0])
      6'h20: e.op = 3'b010;
      6'h22: e.op = 3'b110;
      6'h24: e.op = 3'b000;
      6'h25: e.op = 3'b001;
      6'h2A: begin e.op = 3'b111; e.sl = 1'b1; end
      6'h2B: begin e.op = 3'b101; e.sl = 1'b1; end
      6'h00: begin e.op = 3'b011; e.sh = 1'b1; end
      6'h02: begin e.op = 3'b100; e.sh = 1'b1; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_bad);
    logic [31:0] w;
    logic [5:0] f;
    case ($urandom_range(0, 7))
      0: f = 6'h20;
      1: f = 6'h22;
      2: f = 6'h24;
      3: f = 6'h25;
      4: f = 6'h2A;
      5: f = 6'h2B;
      6: f = 6'h00;
      default: f = 6'h02;
    endcase
    w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), f};
    if ($urandom_range(0, 4) == 0) w[15:11] = 5'd0;
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 0) w[31:26] = 6'($urandom_range(1, 62));
      else w[5:0] = 6'h21;
    end
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_a, rd_en_a, wr_en_a, busy_a, halted_a} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000", {req_a, rd_en_a, wr_en_a, busy_a, halted_a});
    end
    checks++;
    if ({addr_a, ret_a, rs_a, rt_a, rd_a, op_a, sh_a, sl_a} !== '0) begin
      errors++; $display("FAIL reset_values: addr=%h ret=%h rs=%h rt=%h rd=%h op=%b expected all zero", addr_a, ret_a, rs_a, rt_a, rd_a, op_a);
    end
    checks++;
    if ({req_b, busy_b, halted_b, addr_b, ret_b} !== '0) begin
      errors++; $display("FAIL reset_small: req=%b busy=%b halted=%b addr=%h ret=%h expected all zero", req_b, busy_b, halted_b, addr_b, ret_b);
    end
`ifdef RTYPE_ILLEGAL_TRAP_EN
    checks++;
    if ({trap_a, trap_pc_a} !== '0) begin
      errors++; $display("FAIL reset_trap: trap=%b trap_pc=%h expected 0", trap_a, trap_pc_a);
    end
`endif
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_add_halt();
    int first_wr = -1, n_wr = 0, overlap = 0;
    bit done = 1'b0;
    logic busy1 = 1'b0;
    exp_t got = '0;
    mem_a[0] = 32'h0022_1820; mem_a[1] = HALT;
    fixed_wait_a = 0; rand_wait_a = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) busy1 = busy_a;
      if (rd_en_a && wr_en_a) overlap++;
      if (wr_en_a) begin
        n_wr++;
        if (first_wr < 0) begin first_wr = cyc; got = '{rs_a, rt_a, rd_a, op_a, sh_a, sl_a}; end
      end
      if (cyc > 0 && halted_a) begin done = 1'b1; break; end
      @(posedge clk); #1 start_a = 1'b0;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL add_timeout: halted=%b expected 1", halted_a); end
    checks++;
    if (first_wr != 4) begin errors++; $display("FAIL add_latency: wr_en at cycle %0d expected 4", first_wr); end
    checks++;
    if (n_wr != 1) begin errors++; $display("FAIL add_wr_count: %0d expected 1", n_wr); end
    checks++;
    if (got !== exp_t'({5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b0})) begin
      errors++; $display("FAIL add_fields: got %h expected %h", got, exp_t'({5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b0}));
    end
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", busy1); end
    checks++;
    if ({ret_a, addr_a, busy_a} !== {16'd1, 8'd1, 1'b0}) begin
      errors++; $display("FAIL add_final: ret=%0d addr=%0d busy=%b expected 1 1 0", ret_a, addr_a, busy_a);
    end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL add_overlap: %0d cycles with both strobes expected 0", overlap); end
  endtask

  task automatic test_shift_wait();
    int req_first = 0, n_wr = 0;
    bit seen_exec = 1'b0, done = 1'b0;
    exp_t got = '0;
    mem_a[0] = 32'h0002_2900; mem_a[1] = HALT;
    fixed_wait_a = 3;
    @(posedge clk); #1 start_a = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (req_a && !seen_exec) req_first++;
      if (rd_en_a && !seen_exec) begin seen_exec = 1'b1; got = '{rs_a, rt_a, rd_a, op_a, sh_a, sl_a}; end
      if (wr_en_a) n_wr++;
      if (cyc > 0 && halted_a) begin done = 1'b1; break; end
      @(posedge clk); #1 start_a = 1'b0;
    end
    fixed_wait_a = 0;
    checks++;
    if (!done) begin errors++; $display("FAIL sll_timeout: halted=%b expected 1", halted_a); end
    checks++;
    if (req_first != 4) begin errors++; $display("FAIL sll_req_hold: %0d cycles expected 4", req_first); end
    checks++;
    if (got !== exp_t'({5'd0, 5'd2, 5'd5, 3'b011, 1'b1, 1'b0})) begin
      errors++; $display("FAIL sll_fields: got %h expected %h", got, exp_t'({5'd0, 5'd2, 5'd5, 3'b011, 1'b1, 1'b0}));
    end
    checks++;
    if (n_wr != 1 || ret_a !== 16'd1) begin errors++; $display("FAIL sll_retire: wr=%0d ret=%0d expected 1 1", n_wr, ret_a); end
  endtask

  task automatic test_slt_rd0();
    int n_wr = 0;
    bit done = 1'b0;
    logic sl_seen = 1'b0;
    logic [2:0] op_seen = '0;
    mem_a[0] = 32'h0022_002A; mem_a[1] = HALT;
    @(posedge clk); #1 start_a = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (rd_en_a) begin sl_seen = sl_a; op_seen = op_a; end
      if (wr_en_a) n_wr++;
      if (cyc > 0 && halted_a) begin done = 1'b1; break; end
      @(posedge clk); #1 start_a = 1'b0;
    end
    checks++;
    if (!done || {sl_seen, op_seen} !== 4'b1111) begin
      errors++; $display("FAIL slt_ctrl: done=%b sltu_sel=%b op=%b expected 1 1 111", done, sl_seen, op_seen);
    end
    checks++;
    if (n_wr != 0) begin errors++; $display("FAIL slt_rd0_write: %0d wr_en pulses expected 0", n_wr); end
    checks++;
    if (ret_a !== 16'd1) begin errors++; $display("FAIL slt_rd0_retired: got %0d expected 1", ret_a); end
  endtask

  task automatic test_illegal();
    int n_exec = 0;
    bit done = 1'b0, stop;
    mem_a[0] = 32'h8C22_0000; mem_a[1] = HALT;
    @(posedge clk); #1 start_a = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (rd_en_a) n_exec++;
      stop = halted_a;
`ifdef RTYPE_ILLEGAL_TRAP_EN
      stop = stop | trap_a;
`endif
      if (cyc > 0 && stop) begin done = 1'b1; break; end
      @(posedge clk); #1 start_a = 1'b0;
    end
    checks++;
    if (!done || n_exec != 0) begin errors++; $display("FAIL lw_exec: done=%b execs=%0d expected 1 0", done, n_exec); end
`ifdef RTYPE_ILLEGAL_TRAP_EN
    checks++;
    if ({trap_a, trap_pc_a, halted_a} !== {1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL lw_trap: trap=%b trap_pc=%0d halted=%b expected 1 0 0", trap_a, trap_pc_a, halted_a);
    end
    mem_a[0] = HALT;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({trap_a, halted_a} !== 2'b01) begin errors++; $display("FAIL trap_restart: trap=%b halted=%b expected 0 1", trap_a, halted_a); end
`else
    checks++;
    if ({halted_a, addr_a, ret_a} !== {1'b1, 8'd1, 16'd0}) begin
      errors++; $display("FAIL lw_skip: halted=%b addr=%0d ret=%0d expected 1 1 0", halted_a, addr_a, ret_a);
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    int n_wr = 0;
    mem_a[0] = 32'h0022_1820;
    fixed_wait_a = 1000;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_a !== 1'b1) begin errors++; $display("FAIL midfetch_req: got %b expected 1", req_a); end
    @(posedge clk); #3 reset = 1'b1;
    #1;
    checks++;
    if ({req_a, busy_a, rd_en_a, wr_en_a, addr_a, ret_a, rs_a, rt_a, rd_a, op_a, sh_a, sl_a} !== '0) begin
      errors++; $display("FAIL midfetch_reset: req=%b busy=%b addr=%h rs=%h rt=%h rd=%h op=%b expected all zero",
                         req_a, busy_a, addr_a, rs_a, rt_a, rd_a, op_a);
    end
    repeat (3) begin @(negedge clk); if (wr_en_a) n_wr++; end
    @(posedge clk); #1 reset = 1'b0;
    fixed_wait_a = 0;
    repeat (2) begin @(negedge clk); if (wr_en_a) n_wr++; end
    checks++;
    if (n_wr != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL midfetch_after: wr=%0d busy=%b expected 0 0", n_wr, busy_a); end
  endtask

  task automatic test_wrap_small();
    int seq [8];
    int n_fetch = 0, n_busy_start = 0;
    bit swapped = 1'b0, prev_req = 1'b0, done = 1'b0;
    for (int i = 0; i < 4; i++) mem_b[i] = 32'h0022_1820;
    @(posedge clk); #1 start_b = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (req_b && !prev_req && n_fetch < 8) begin seq[n_fetch] = int'(addr_b); n_fetch++; end
      prev_req = req_b;
      if (req_b && addr_b != 2'd0 && !swapped) begin mem_b[0] = HALT; swapped = 1'b1; end
      if (start_b && busy_b) n_busy_start++;
      if (cyc > 0 && halted_b) begin done = 1'b1; break; end
      @(posedge clk); #1 start_b = (cyc == 5 || cyc == 9);
    end
    start_b = 1'b0;
    checks++;
    if (!done || n_busy_start != 2) begin errors++; $display("FAIL wrap_done: done=%b busy_starts=%0d expected 1 2", done, n_busy_start); end
    checks++;
    if (n_fetch != 5 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 0) begin
      errors++; $display("FAIL wrap_addrs: n=%0d seq=%0d %0d %0d %0d %0d expected 5: 0 1 2 3 0", n_fetch, seq[0], seq[1], seq[2], seq[3], seq[4]);
    end
    checks++;
    if ({ret_b, addr_b} !== {16'd4, 2'd0}) begin errors++; $display("FAIL wrap_final: ret=%0d addr=%0d expected 4 0", ret_b, addr_b); end
  endtask

  task automatic test_random_programs();
    exp_t exp_q[$];
    exp_t e, got;
    int n, exp_ret, exec_err, wr_err, overlap;
    bit done, pend_wr, allow_bad;
    logic pend_val;
`ifdef RTYPE_ILLEGAL_TRAP_EN
    allow_bad = 1'b0;
`else
    allow_bad = 1'b1;
`endif
    rand_wait_a = 1'b1;
    for (int p = 0; p < 4; p++) begin
      exp_q.delete();
      n = $urandom_range(6, 14);
      exp_ret = 0;
      for (int i = 0; i < n; i++) begin
        mem_a[i] = rand_word(allow_bad);
        if (model_decode(mem_a[i], e)) begin exp_q.push_back(e); exp_ret++; end
      end
      mem_a[n] = HALT;
      exec_err = 0; wr_err = 0; overlap = 0; done = 1'b0; pend_wr = 1'b0; pend_val = 1'b0;
      @(posedge clk); #1 start_a = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        if (rd_en_a && wr_en_a) overlap++;
        if (pend_wr && wr_en_a !== pend_val) wr_err++;
        pend_wr = 1'b0;
        if (rd_en_a) begin
          got = '{rs_a, rt_a, rd_a, op_a, sh_a, sl_a};
          if (exp_q.size() == 0) exec_err++;
          else begin
            e = exp_q.pop_front();
            if (got !== e) begin exec_err++; $display("[TB] prog %0d exec got %h expected %h", p, got, e); end
            pend_wr = 1'b1; pend_val = (e.rd != 5'd0);
          end
        end
        if (cyc > 0 && halted_a) begin done = 1'b1; break; end
        @(posedge clk); #1 start_a = 1'b0;
      end
      checks++;
      if (!done || exp_q.size() != 0) begin errors++; $display("FAIL rand_complete: done=%b left=%0d expected 1 0", done, exp_q.size()); end
      checks++;
      if (exec_err != 0 || wr_err != 0 || overlap != 0) begin
        errors++; $display("FAIL rand_exec: field_errs=%0d wr_errs=%0d overlaps=%0d expected 0 0 0", exec_err, wr_err, overlap);
      end
      checks++;
      if ({ret_a, addr_a} !== {16'(exp_ret), 8'(n)}) begin
        errors++; $display("FAIL rand_final: ret=%0d addr=%0d expected %0d %0d", ret_a, addr_a, exp_ret, n);
      end
    end
    rand_wait_a = 1'b0;
  endtask

  initial begin
    $display("[TB] starting");
    test_reset();
    test_add_halt();
    test_shift_wait();
    test_slt_rd0();
    test_illegal();
    test_reset_mid_fetch();
    test_wrap_small();
    test_random_programs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_exec_sequencer.md
Name: rtype_exec_sequencer

Overview:
- Multi-cycle controller that drives the structural R-type MIPS datapath (register block, shamt extender, ALU, ALU control).
- Fetches 32-bit words from an instruction memory over a valid/ready handshake and decodes R-type fields.
- Sequences the register-file read, ALU execute and rd write-back phases, then advances the PC until a HALT word.
- Sits between the instruction memory and the datapath; it replaces the free-running combinational read/write pair with explicit per-phase enables.

Parameters:
- PC_W, 8, instruction address width (word address).
- START_PC, 0, PC value loaded on reset and on each start pulse.
- HALT_WORD, 32'hFC00_0000, instruction word that ends execution.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; starts execution from START_PC when in IDLE or HALTED.
- imem_req  output  1  fetch request, held high until accepted.
- imem_addr  output  PC_W  word address of the fetch.
- imem_valid  input  1  fetch data valid; the transfer completes when imem_req and imem_valid are both high.
- imem_rdata  input  32  fetched instruction word.
- rf_rs  output  5  register-file read address A.
- rf_rt  output  5  register-file read address B.
- rf_rd  output  5  register-file write address.
- rf_rd_en  output  1  register-file read strobe (EXECUTE).
- rf_wr_en  output  1  register-file write strobe (WRITEBACK).
- alu_op  output  3  ALU operation code (package constants).
- shift_sel  output  1  1 = operand pair is (rt, zero-extended shamt); 0 = (rs, rt).
- sltu_sel  output  1  selects the 0/1 slt/sltu result onto the write-back bus.
- busy  output  1  high in every state except IDLE and HALTED.
- halted  output  1  high in the HALTED state.
- retired  output  16  count of completed write-backs, saturating at 16'hFFFF.

Behaviour:
- Reset: state IDLE; PC = START_PC; retired = 0; all strobes, imem_req, busy and halted = 0; rf_* addresses, alu_op, shift_sel and sltu_sel = 0.
- IDLE: when start = 1, load PC = START_PC, clear retired, go to FETCH.
- FETCH:
  - imem_req = 1, imem_addr = PC.
  - On handshake, capture imem_rdata into the IR and go to DECODE.
  - Waits indefinitely for imem_valid; imem_req stays high while waiting.
- DECODE (1 cycle):
  - If IR == HALT_WORD, go to HALTED; the PC does not advance.
  - If opcode != 0 or funct is unsupported, PC = PC+1 and go to FETCH with no write-back.
  - Otherwise latch rs/rt/rd/shamt and the control outputs, then go to EXECUTE.
- EXECUTE (1 cycle): rf_rd_en = 1; ALU settles; go to WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_wr_en = 1 unless rd == 0; a write to rd == 0 is suppressed but still counted as retired.
  - retired += 1, saturating.
  - PC = PC+1, wrapping modulo 2^PC_W.
  - Go to FETCH.
- HALTED: holds all outputs; start restarts as from IDLE.
- Latency: a supported instruction takes 3 cycles plus the fetch wait, i.e. 4 cycles minimum with zero-wait memory.
- Supported funct codes and their alu_op / shift_sel / sltu_sel:
  - 0x20 add: ADD, 0, 0.
  - 0x22 sub: SUB, 0, 0.
  - 0x24 and: AND, 0, 0.
  - 0x25 or: OR, 0, 0.
  - 0x2A slt: SLT, 0, 1.
  - 0x2B sltu: SLTU, 0, 1.
  - 0x00 sll: SLL, 1, 0.
  - 0x02 srl: SRL, 1, 0.
- start while busy is ignored.
- Reset asserted mid-operation aborts immediately, with no partial write.
- rf_rd_en and rf_wr_en are never high in the same cycle.

Optional Feature:
- Macro RTYPE_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode or funct moves the block to a TRAP state instead of skipping.
  - Adds outputs trap (1) and trap_pc (PC_W) in TRAP; trap_pc holds the offending PC.
  - Leaves TRAP only on start (restart) or reset.
  - trap and trap_pc reset to 0.
- Undefined: unsupported words are skipped silently, as described under Behaviour.

Decomposition:
- Package rtype_seq_pkg:
  - State enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, TRAP).
  - ALU op constants: AND=000, OR=001, ADD=010, SLL=011, SRL=100, SLTU=101, SUB=110, SLT=111.
  - Funct constants and the field bit positions.
- Sub-module rtype_decoder: combinational IR-to-controls decode (fields, alu_op, shift_sel, sltu_sel, legal flag). The FSM, PC and counter stay in the top.

Test Plan:
- Reset mid-FETCH with imem_req=1 → all outputs return to reset values in the same cycle; no rf_wr_en pulse.
- start; zero-wait memory returns 0x00221820 (add $3,$1,$2), then HALT_WORD → one rf_wr_en pulse with rf_rd=3, alu_op=010, shift_sel=0, 4 cycles after start; then halted=1, retired=1, imem_addr=1.
- Memory returns 0x00022900 (sll $5,$2,4) with imem_valid delayed 3 cycles → imem_req held 4 cycles; then rf_rt=2, rf_rd=5, shift_sel=1, alu_op=011.
- Word 0x0022002A (slt with rd=0) → sltu_sel=1, rf_wr_en stays 0, retired still increments.
- Word 0x8C220000 (lw) followed by HALT_WORD → macro undefined: skipped, PC advances to 1, retired=0. Macro defined: trap=1, trap_pc=0, later start clears trap.
- PC_W=2 with 4 add words followed by HALT_WORD at address 0 → imem_addr wraps 3→0 and the block halts; start pulses while busy are ignored.
